// File: rtl/ftdi_rx_reader.sv
// ftdi_rx_reader
//   Read master for the FT600/601 245-mode synchronous FIFO bus (PC -> FPGA direction).
//   Runs on the FTDI clock, drives OE_N/RD_N, captures DATA/BE into a small
//   first-word-fall-through buffer and presents the words on a valid/ready stream.
//   An optional checker flags breaks in an incrementing-counter test pattern.
//   DATA/BE tristates live in the top level; only the input path arrives here.
//
// Ports
//   clk        FTDI clock (100 MHz)
//   rst        synchronous, active-high reset
//   rxf_n      FTDI RXF_N, low = FTDI has data
//   data_in    FTDI DATA input path (32 bit)
//   be_in      FTDI BE input path (4 bit)
//   oe_n       FTDI OE_N, registered
//   rd_n       FTDI RD_N, registered
//   out_data   head-of-buffer data word (combinational)
//   out_be     head-of-buffer byte enables (combinational)
//   out_valid  head entry valid (combinational)
//   out_ready  consumer accepts head when out_valid & out_ready
//   word_cnt   words pushed since reset, wraps at 2^32
//   seq_err    sticky: popped word != previous popped word + 1
//   ovf_err    sticky: push attempted while buffer full
module ftdi_rx_reader #(
    parameter int unsigned BUF_DEPTH = 8,
    parameter int unsigned RESERVE   = 2,
    parameter bit          CHECK_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxf_n,
    input  logic [31:0] data_in,
    input  logic [3:0]  be_in,
    output logic        oe_n,
    output logic        rd_n,
    output logic [31:0] out_data,
    output logic [3:0]  out_be,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] word_cnt,
    output logic        seq_err,
    output logic        ovf_err
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] StopLevel = CntW'(BUF_DEPTH - RESERVE);
    localparam logic [CntW-1:0] FullLevel = CntW'(BUF_DEPTH);

    typedef enum logic [1:0] {StIdle, StOe, StRead, StDone} state_e;

    state_e               state_q;
    logic [35:0]          mem_q [BUF_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic [31:0]          word_cnt_q;
    logic                 ovf_err_q;

    logic room;
    logic go;
    logic push_req;
    logic full;
    logic pop;
    logic push;

    // Stop decision uses the registered count; RESERVE absorbs the word that is
    // still sampled on the edge where rd_n is being raised.
    assign room     = (count_q < StopLevel);
    assign go       = ~rxf_n & room;
    assign push_req = ~rd_n & ~rxf_n;
    assign full     = (count_q == FullLevel);
    assign pop      = out_valid & out_ready;
    // A simultaneous pop frees a slot, so push-while-full is legal then.
    assign push     = push_req & (~full | pop);

    // Bus FSM with registered OE_N/RD_N.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            oe_n    <= 1'b1;
            rd_n    <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (go) begin
                        state_q <= StOe;
                        oe_n    <= 1'b0;
                        rd_n    <= 1'b1;
                    end
                end
                StOe: begin
                    // One turnaround cycle with OE_N low before RD_N.
                    if (go) begin
                        state_q <= StRead;
                        rd_n    <= 1'b0;
                    end else begin
                        state_q <= StDone;
                    end
                end
                StRead: begin
                    if (!go) begin
                        state_q <= StDone;
                        rd_n    <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    oe_n    <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    oe_n    <= 1'b1;
                    rd_n    <= 1'b1;
                end
            endcase
        end
    end

    // Buffer storage, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {be_in, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            word_cnt_q <= '0;
            ovf_err_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                word_cnt_q <= word_cnt_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && full && !pop) begin
                ovf_err_q <= 1'b1;
            end
        end
    end

    assign {out_be, out_data} = mem_q[rd_ptr_q];
    assign out_valid          = (count_q != '0);
    assign word_cnt           = word_cnt_q;
    assign ovf_err            = ovf_err_q;

    if (CHECK_EN) begin : g_check
        logic        seeded_q;
        logic [31:0] expect_q;
        logic        seq_err_q;

        // Every pop reseeds from the popped word, so a break is reported once and
        // the pattern is then followed from the new value.
        always_ff @(posedge clk) begin
            if (rst) begin
                seeded_q  <= 1'b0;
                expect_q  <= '0;
                seq_err_q <= 1'b0;
            end else if (pop) begin
                seeded_q <= 1'b1;
                expect_q <= out_data + 32'd1;
                if (seeded_q && (out_data != expect_q)) begin
                    seq_err_q <= 1'b1;
                end
            end
        end

        assign seq_err = seq_err_q;
    end else begin : g_no_check
        assign seq_err = 1'b0;
    end

endmodule

// File: tb/tb_ftdi_rx_reader.sv
// tb_ftdi_rx_reader
//   Directed bench for ftdi_rx_reader. A behavioural FTDI source hands out words
//   from a table whenever RD_N is low and RXF_N is low; a consumer pops with a
//   selectable ready pattern and compares against the same table in order.
module tb_ftdi_rx_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxf_n = 1'b1;
    logic [31:0] data_in = '0;
    logic [3:0]  be_in = '0;
    logic        oe_n;
    logic        rd_n;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] word_cnt;
    logic        seq_err;
    logic        ovf_err;

    ftdi_rx_reader dut (
        .clk       (clk),
        .rst       (rst),
        .rxf_n     (rxf_n),
        .data_in   (data_in),
        .be_in     (be_in),
        .oe_n      (oe_n),
        .rd_n      (rd_n),
        .out_data  (out_data),
        .out_be    (out_be),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt),
        .seq_err   (seq_err),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] src [0:10239];
    int  src_len = 0;
    int  src_idx = 0;
    int  pop_idx = 0;
    bit  pend = 1'b0;
    int  ready_mode = 0;
    bit  gap = 1'b0;
    bit  rand_gap = 1'b0;
    int  exp_wc = 0;
    int  occ = 0;
    int  max_occ = 0;
    int  viol = 0;
    int  cyc = 0;
    int  oe_fall = -1;
    int  rd_fall = -1;
    bit  seq_hist [0:63];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of FTDI source + consumer, evaluated on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pend) begin
            src_idx++;
            exp_wc++;
        end
        occ = src_idx - pop_idx;
        if (occ > max_occ) max_occ = occ;
        if (!rd_n && oe_n) viol++;
        if (oe_fall < 0 && !oe_n) oe_fall = cyc;
        if (rd_fall < 0 && !rd_n) rd_fall = cyc;
        if (pop_idx < 64) seq_hist[pop_idx] = seq_err;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (rand_gap) gap = ($urandom_range(0, 3) == 0);
        rxf_n   = !(src_idx < src_len && !gap);
        data_in = rxf_n ? 32'hBAD0_BAD0 : src[src_idx];
        be_in   = rxf_n ? 4'h0 : 4'hF;
        pend    = !rd_n && !rxf_n;
        if (out_valid && out_ready) begin
            if (pop_idx < src_len) begin
                check("pop_data", out_data, src[pop_idx]);
                check("pop_be", out_be, 4'hF);
            end else begin
                check("pop_extra", pop_idx, src_len);
            end
            pop_idx++;
        end
    endtask

    task automatic load(input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++) src[i] = first + 32'(i);
        for (int i = 0; i < 64; i++) seq_hist[i] = 1'b0;
        src_len = n;
        src_idx = 0;
        pop_idx = 0;
        oe_fall = -1;
        rd_fall = -1;
        max_occ = 0;
        cyc     = 0;
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (pop_idx < src_len && n < budget) begin
            step();
            n++;
        end
        check(tag, pop_idx, src_len);
        repeat (3) step();
    endtask

    // Called on a falling edge: one-cycle reset pulse, bench state cleared.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        pend    = 1'b0;
        exp_wc  = 0;
        src_len = 0;
        src_idx = 0;
        pop_idx = 0;
    endtask

    task automatic check_reset_state();
        check("rst_oe_n", oe_n, 1'b1);
        check("rst_rd_n", rd_n, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_word_cnt", word_cnt, 32'd0);
        check("rst_seq_err", seq_err, 1'b0);
        check("rst_ovf_err", ovf_err, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check_reset_state();

        // 1) basic burst of 16 words with the consumer always ready
        ready_mode = 1;
        load(16, 32'd0);
        drain(200, "t1_pops");
        check("t1_oe_seen", oe_fall >= 0, 1'b1);
        check("t1_oe_leads_rd", 32'(rd_fall - oe_fall), 32'd1);
        check("t1_word_cnt", word_cnt, 32'd16);
        check("t1_seq_err", seq_err, 1'b0);
        check("t1_ovf_err", ovf_err, 1'b0);

        // 2) consumer stalled: reader must stop with the reserve intact
        ready_mode = 0;
        load(20, 32'd16);
        repeat (30) step();
        check("t2_fill_in_range", (occ >= 6 && occ <= 8), 1'b1);
        check("t2_max_fill", max_occ <= 8, 1'b1);
        check("t2_rd_n_high", rd_n, 1'b1);
        check("t2_oe_n_high", oe_n, 1'b1);
        check("t2_ovf_err", ovf_err, 1'b0);
        ready_mode = 1;
        drain(300, "t2_pops");
        check("t2_word_cnt", word_cnt, 32'd36);

        // 3) RXF_N rises mid-burst, then falls again
        load(12, 32'd36);
        while (src_idx < 6 && cyc < 100) step();
        gap = 1'b1;
        repeat (5) step();
        check("t3_gap_oe_n", oe_n, 1'b1);
        check("t3_gap_rd_n", rd_n, 1'b1);
        check("t3_gap_word_cnt", word_cnt, 32'(exp_wc));
        gap = 1'b0;
        drain(200, "t3_pops");
        check("t3_word_cnt", word_cnt, 32'd48);
        check("t3_seq_err", seq_err, 1'b0);

        // 4a) counter wrap is not a sequence break
        do_reset();
        load(4, 32'hFFFF_FFFE);
        drain(100, "t4a_pops");
        check("t4a_seq_err", seq_err, 1'b0);
        check("t4a_word_cnt", word_cnt, 32'd4);

        // 4b) 3,4,6,7: error appears on the pop of 6 and sticks
        do_reset();
        load(4, 32'd3);
        src[2] = 32'd6;
        src[3] = 32'd7;
        drain(100, "t4b_pops");
        check("t4b_after_4", seq_hist[2], 1'b0);
        check("t4b_after_6", seq_hist[3], 1'b1);
        check("t4b_after_7", seq_hist[4], 1'b1);
        check("t4b_sticky", seq_err, 1'b1);

        // 5) reset during READ with three words buffered
        ready_mode = 0;
        load(20, 32'd500);
        while (occ < 3 && cyc < 50) step();
        check("t5_occ", occ, 3);
        check("t5_in_read", rd_n, 1'b0);
        do_reset();
        check_reset_state();
        ready_mode = 1;
        load(8, 32'd100);
        drain(100, "t5_pops");
        check("t5_word_cnt", word_cnt, 32'd8);
        check("t5_seq_err", seq_err, 1'b0);

        // 6) random ready and random RXF_N gaps, 10000 words
        ready_mode = 2;
        rand_gap   = 1'b1;
        load(10000, 32'd108);
        drain(60000, "t6_pops");
        rand_gap = 1'b0;
        gap      = 1'b0;
        check("t6_word_cnt", word_cnt, 32'(exp_wc));
        check("t6_word_cnt_abs", word_cnt, 32'd10008);
        check("t6_max_fill", max_occ <= 8, 1'b1);
        check("t6_ovf_err", ovf_err, 1'b0);
        check("t6_seq_err", seq_err, 1'b0);
        check("oe_rd_protocol", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
